// File: rtl/vga_digit_display.sv
// vga_digit_display: 640x480 timing generator that renders NUM_DIGITS
// seven-segment glyphs plus an optional blinking colon.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero
// cells (the rightmost cell is always drawn).
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   pix_en       - pixel-rate enable; all state advances only when set
//   digits       - 4-bit codes, digits[4i+3:4i] is cell i (cell 0 leftmost)
//   load         - captures digits into the pending register
//   colon_blink  - 1: colon blinks every BLINK_FRAMES frames, 0: steady on
//   hsync, vsync - active-low syncs
//   video_on     - visible-area flag aligned with rgb
//   rgb          - pixel colour
module vga_digit_display #(
  parameter int NUM_DIGITS = 4,
  parameter int ORIGIN_X = 15,
  parameter int ORIGIN_Y = 100,
  parameter int DIGIT_W = 80,
  parameter int DIGIT_H = 120,
  parameter int SEG_T = 12,
  parameter int GAP = 15,
  parameter int COLON_AFTER = 1,
  parameter int COLON_W = 20,
  parameter logic [7:0] FG = 8'hC0,
  parameter logic [7:0] BG = 8'h00,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pix_en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    load,
  input  logic                    colon_blink,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    video_on,
  output logic [7:0]              rgb
);

  localparam int unsigned CW = 10;
  localparam int unsigned DW = 4 * NUM_DIGITS;
  localparam int unsigned BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam int unsigned H_TOTAL = 800;
  localparam int unsigned H_VIS = 640;
  localparam int unsigned H_SYNC_S = 656;
  localparam int unsigned H_SYNC_E = 751;
  localparam int unsigned V_TOTAL = 525;
  localparam int unsigned V_VIS = 480;
  localparam int unsigned V_SYNC_S = 490;
  localparam int unsigned V_SYNC_E = 491;

  // Left x of digit cell i; cells right of the colon shift by the colon cell.
  function automatic int cell_x(input int i);
    int x;
    x = ORIGIN_X + i * (DIGIT_W + GAP);
    if (i > COLON_AFTER) x = x + COLON_W + GAP;
    return x;
  endfunction

  localparam bit HAS_COLON = (COLON_AFTER < NUM_DIGITS);
  localparam int COLON_X = cell_x(COLON_AFTER) + DIGIT_W + GAP + (COLON_W - SEG_T) / 2;
  localparam int DOT1_Y = DIGIT_H / 3 - SEG_T / 2;
  localparam int DOT2_Y = (2 * DIGIT_H) / 3 - SEG_T / 2;
  localparam int G_TOP = DIGIT_H / 2 - SEG_T / 2;
  localparam int HALF_H = DIGIT_H / 2;

  // Segment bits ordered {a,b,c,d,e,f,g}; codes A-F are dark.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    case (code)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  logic [CW-1:0]  h_cnt, v_cnt;
  logic           h_last_c, v_last_c, frame_tick_c;
  logic [DW-1:0]  pend, disp;
  logic           pend_vld;
  logic [BCW-1:0] blink_cnt;
  logic           blink_phase;
  logic [CW-1:0]  h1, v1;
  logic           hs1, vs1, vis1;
  logic [NUM_DIGITS-1:0] blank_c;
  logic           hit_c;
  int             x_c, y_c, rx_c;
  logic [6:0]     segs_c;
  logic           upper_c, left_c, right_c;

  assign h_last_c = (h_cnt == CW'(H_TOTAL - 1));
  assign v_last_c = (v_cnt == CW'(V_TOTAL - 1));
  // Tick on which the counters move to (0,480): the first blanked line.
  assign frame_tick_c = pix_en && h_last_c && (v_cnt == CW'(V_VIS - 1));

  // Raster counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      h_cnt <= h_last_c ? '0 : h_cnt + CW'(1);
      if (h_last_c) v_cnt <= v_last_c ? '0 : v_cnt + CW'(1);
    end
  end

  // Pending/display digit registers; display only changes at the frame tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend     <= '0;
      disp     <= '0;
      pend_vld <= 1'b0;
    end else if (pix_en) begin
      if (frame_tick_c) begin
        disp     <= load ? digits : pend;
        pend_vld <= 1'b0;
        if (load) pend <= digits;
      end else if (load) begin
        pend     <= digits;
        pend_vld <= 1'b1;
      end
    end
  end

  // Colon blink: frame counter toggling the phase every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_tick_c) begin
      if (blink_cnt == BCW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BCW'(1);
      end
    end
  end

  // Stage 1: coordinates and sync/visible decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      h1   <= '0;
      v1   <= '0;
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      vis1 <= 1'b0;
    end else if (pix_en) begin
      h1   <= h_cnt;
      v1   <= v_cnt;
      hs1  <= !((h_cnt >= CW'(H_SYNC_S)) && (h_cnt <= CW'(H_SYNC_E)));
      vs1  <= !((v_cnt >= CW'(V_SYNC_S)) && (v_cnt <= CW'(V_SYNC_E)));
      vis1 <= (h_cnt < CW'(H_VIS)) && (v_cnt < CW'(V_VIS));
    end
  end

  // Leading-zero blanking mask over the displayed digits.
`ifdef LEADING_ZERO_BLANK_EN
  logic lead_c;
  always_comb begin
    blank_c = '0;
    lead_c  = 1'b1;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      if (lead_c && (disp[4*i +: 4] == 4'd0)) blank_c[i] = 1'b1;
      else lead_c = 1'b0;
    end
  end
`else
  always_comb begin
    blank_c = '0;
  end
`endif

  // Segment/colon hit test for the stage-1 pixel.
  always_comb begin
    hit_c   = 1'b0;
    x_c     = int'(h1);
    y_c     = int'(v1) - ORIGIN_Y;
    rx_c    = 0;
    segs_c  = '0;
    upper_c = 1'b0;
    left_c  = 1'b0;
    right_c = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      segs_c  = blank_c[i] ? 7'd0 : seg_decode(disp[4*i +: 4]);
      rx_c    = x_c - cell_x(i);
      upper_c = (y_c < HALF_H);
      left_c  = (rx_c < SEG_T);
      right_c = (rx_c >= DIGIT_W - SEG_T);
      if ((rx_c >= 0) && (rx_c < DIGIT_W) && (y_c >= 0) && (y_c < DIGIT_H)) begin
        if ((segs_c[6] && (y_c < SEG_T)) ||
            (segs_c[0] && (y_c >= G_TOP) && (y_c < G_TOP + SEG_T)) ||
            (segs_c[3] && (y_c >= DIGIT_H - SEG_T)) ||
            (segs_c[5] && right_c && upper_c) ||
            (segs_c[4] && right_c && !upper_c) ||
            (segs_c[2] && left_c && !upper_c) ||
            (segs_c[1] && left_c && upper_c))
          hit_c = 1'b1;
      end
    end
    if (HAS_COLON && (!colon_blink || blink_phase) &&
        (x_c >= COLON_X) && (x_c < COLON_X + SEG_T) &&
        (((y_c >= DOT1_Y) && (y_c < DOT1_Y + SEG_T)) ||
         ((y_c >= DOT2_Y) && (y_c < DOT2_Y + SEG_T))))
      hit_c = 1'b1;
  end

  // Stage 2: registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
      rgb      <= 8'h00;
    end else if (pix_en) begin
      hsync    <= hs1;
      vsync    <= vs1;
      video_on <= vis1;
      rgb      <= vis1 ? (hit_c ? FG : BG) : 8'h00;
    end
  end

endmodule
